// File: rtl/apb_slave_pkg.sv
// Shared types and default widths for the APB register-bank completer.
package apb_slave_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] OOR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    typedef logic [DATA_W-1:0] apb_data_t;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with a zero flag, used to time APB wait states.
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : value to load
//   i_dec        : decrement by one, saturating at zero
//   o_zero_c     : counter is zero (decoded from the count register)
module apb_wait_ctr #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory with run-time
// programmable wait states per transfer.
//   clk, reset          : clock, synchronous active-high reset
//   psel, penable       : APB select / access-phase enable
//   paddr, pwrite       : word address, 1 = write
//   pwdata              : write data
//   pready              : transfer complete (decoded from state and wait counter)
//   prdata              : read data, held until the next read's setup
//   wait_cycles         : wait states for the transfer, sampled at setup
//   xfer_count          : completed-transfer count, wraps
module apb_slave_mem #(
    parameter int unsigned       ADDR_W    = apb_slave_pkg::ADDR_W,
    parameter int unsigned       DATA_W    = apb_slave_pkg::DATA_W,
    parameter int unsigned       DEPTH     = 256,
    parameter logic [DATA_W-1:0] OOR_RDATA = DATA_W'(apb_slave_pkg::OOR_RDATA)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    input  logic [3:0]        wait_cycles,
    output logic [15:0]       xfer_count
);

    localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);

    apb_slave_pkg::apb_state_e r_state;
    apb_slave_pkg::apb_state_e w_state_nxt;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  r_addr;
    logic              r_addr_ok;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_prdata;
    logic [15:0]       r_xfer_count;

    logic              w_setup;
    logic              w_complete;
    logic              w_dec;
    logic              w_cnt_zero;
    logic              w_paddr_ok;
    logic [IDX_W-1:0]  w_paddr_idx;

    assign w_paddr_ok  = ({1'b0, paddr} < LIMIT);
    assign w_paddr_idx = paddr[IDX_W-1:0];

    apb_wait_ctr #(.W(4)) u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_setup),
        .i_load_val (wait_cycles),
        .i_dec      (w_dec),
        .o_zero_c   (w_cnt_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= apb_slave_pkg::IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and transfer strobes
    always_comb begin
        w_state_nxt = r_state;
        w_setup     = 1'b0;
        w_complete  = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            apb_slave_pkg::IDLE: begin
                // psel with penable but no prior setup is ignored
                if (psel && !penable) begin
                    w_setup     = 1'b1;
                    w_state_nxt = apb_slave_pkg::ACCESS;
                end
            end
            apb_slave_pkg::ACCESS: begin
                if (!psel) begin
                    w_state_nxt = apb_slave_pkg::IDLE;
                end else begin
                    // Counter keeps running even if penable is held low
                    w_dec = !w_cnt_zero;
                    if (penable && w_cnt_zero) begin
                        w_complete  = 1'b1;
                        w_state_nxt = apb_slave_pkg::IDLE;
                    end
                end
            end
            default: w_state_nxt = apb_slave_pkg::IDLE;
        endcase
    end

    // Setup-phase capture, read data and completion bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_addr_ok    <= 1'b0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_prdata     <= '0;
            r_xfer_count <= '0;
        end else begin
            if (w_setup) begin
                r_addr    <= w_paddr_idx;
                r_addr_ok <= w_paddr_ok;
                r_write   <= pwrite;
                r_wdata   <= pwdata;
                if (!pwrite) begin
                    r_prdata <= w_paddr_ok ? r_mem[w_paddr_idx] : OOR_RDATA;
                end
            end
            if (w_complete) begin
                r_xfer_count <= r_xfer_count + 16'd1;
            end
        end
    end

    // Memory array; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_complete && r_write && r_addr_ok) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign pready     = (r_state == apb_slave_pkg::ACCESS) && w_cnt_zero;
    assign prdata     = r_prdata;
    assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed and randomized bench for apb_slave_mem with a memory-array model.
module tb_apb_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel;
    logic        penable;
    logic [9:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic [3:0]  wait_cycles;
    logic [15:0] xfer_count;

    apb_slave_mem dut (
        .clk         (clk),
        .reset       (reset),
        .psel        (psel),
        .penable     (penable),
        .paddr       (paddr),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .wait_cycles (wait_cycles),
        .xfer_count  (xfer_count)
    );

    always #5 clk = ~clk;

    // Reference model: plain memory image, transfer count and last read value
    logic [31:0] mdl_mem [256];
    int          mdl_cnt;
    logic [31:0] mdl_rd;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 256; i++) mdl_mem[i] = 32'h0;
        mdl_cnt = 0;
        mdl_rd  = 32'h0;
    endtask

    task automatic mdl_apply(input logic wr, input logic [9:0] a, input logic [31:0] d);
        if (wr) begin
            if (a < 10'd256) mdl_mem[a] = d;
        end else begin
            mdl_rd = (a < 10'd256) ? mdl_mem[a] : 32'hDEAD_BEEF;
        end
        mdl_cnt = (mdl_cnt + 1) % 65536;
    endtask

    task automatic go_idle();
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
    endtask

    // One full transfer; returns at the negedge after the completion edge with
    // psel still high so a following call produces a back-to-back setup.
    task automatic xfer(input logic wr, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] ws);
        int   waits;
        logic done;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cycles = ws;
        @(negedge clk);
        penable = 1'b1;
        // Bus changes during the access phase must be ignored
        paddr = 10'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
        wait_cycles = 4'($urandom);
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 40) begin
            if (pready === 1'b1) done = 1'b1;
            else begin
                waits++;
                @(negedge clk);
            end
        end
        check("ready_seen", 32'(done), 32'd1);
        check("wait_states", 32'(waits), 32'(ws));
        @(negedge clk);
        mdl_apply(wr, a, d);
        check("xfer_count", 32'(xfer_count), 32'(mdl_cnt));
        check("prdata", prdata, mdl_rd);
    endtask

    initial begin
        reset = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pwdata = '0; wait_cycles = '0;
        mdl_clear();
        @(negedge clk); @(negedge clk);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Zero-wait write then read
        xfer(1'b1, 10'h005, 32'h0000_1234, 4'd0);
        xfer(1'b0, 10'h005, 32'h0, 4'd0);
        check("prdata_1234", prdata, 32'h0000_1234);
        check("count_two", 32'(xfer_count), 32'd2);
        go_idle();

        // Three wait states on a read of untouched memory
        xfer(1'b0, 10'h010, 32'h0, 4'd3);
        go_idle();

        // Out-of-range write dropped, read returns filler
        xfer(1'b1, 10'h3FF, 32'hCAFE_F00D, 4'd0);
        xfer(1'b0, 10'h3FF, 32'h0, 4'd0);
        check("oor_rdata", prdata, 32'hDEAD_BEEF);
        go_idle();

        // Back-to-back with one wait state
        xfer(1'b1, 10'd1, 32'hA, 4'd1);
        xfer(1'b1, 10'd2, 32'hB, 4'd1);
        xfer(1'b0, 10'd1, 32'h0, 4'd1);
        check("b2b_rd1", prdata, 32'hA);
        xfer(1'b0, 10'd2, 32'h0, 4'd1);
        check("b2b_rd2", prdata, 32'hB);
        go_idle();

        // Abort after two access cycles
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'd7; pwdata = 32'h55;
        wait_cycles = 4'd5;
        @(negedge clk);
        penable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("abort_pready", 32'(pready), 32'd0);
            @(negedge clk);
        end
        go_idle();
        check("abort_count", 32'(xfer_count), 32'(mdl_cnt));
        xfer(1'b0, 10'd7, 32'h0, 4'd0);
        check("abort_rd", prdata, 32'h0);
        go_idle();

        // Access phase without setup is ignored
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'd9; pwdata = 32'h77;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("nosetup_pready", 32'(pready), 32'd0);
        end
        check("nosetup_count", 32'(xfer_count), 32'(mdl_cnt));
        go_idle();

        // penable held low in access: ready but no completion
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'd12; pwdata = 32'h1212;
        wait_cycles = 4'd0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("penlow_pready", 32'(pready), 32'd1);
            @(negedge clk);
        end
        check("penlow_count", 32'(xfer_count), 32'(mdl_cnt));
        penable = 1'b1;
        @(negedge clk);
        mdl_apply(1'b1, 10'd12, 32'h1212);
        check("penlow_done", 32'(xfer_count), 32'(mdl_cnt));
        go_idle();
        xfer(1'b0, 10'd12, 32'h0, 4'd0);
        go_idle();

        // Randomized traffic, mixing back-to-back and idle gaps
        for (int n = 0; n < 60; n++) begin
            xfer(1'($urandom), 10'($urandom_range(0, 299)), $urandom,
                 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();

        // Reset in the middle of a write's wait states
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h020; pwdata = 32'h1357_9BDF;
        wait_cycles = 4'd4;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        reset = 1'b1; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        mdl_clear();
        check("midrst_pready", 32'(pready), 32'd0);
        check("midrst_count", 32'(xfer_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        xfer(1'b0, 10'h020, 32'h0, 4'd0);
        check("midrst_rd", prdata, 32'h0);
        go_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
